// File: rtl/prio_decoder_seq.sv
// prio_decoder_seq: receive side of the priority-encoder request path.
// Takes an encoded index (in_code) and its any-active flag (in_z). It then
// drives a registered one-hot pulse for HOLD cycles and keeps a sticky
// per-bit pending register.
//
// Parameters: N    code width; the output is 2**N bits wide.
//             HOLD number of cycles each pulse is driven (1..255).
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   in_valid/ready   handshake; a transfer happens when both are high at a rising edge
//   in_code, in_z    encoded index and its "index meaningful" flag
//   out_onehot       registered one-hot pulse; zero when no pulse is driven
//   out_active       high while out_onehot is nonzero
//   pending, clr     sticky OR of decoded bits, with a per-bit clear (a set wins over a clear)
//   null_cnt         saturating count of accepted codes that have in_z=0
// Optional macro PRIO_DEC_B2B_EN: the block also accepts a code in the last
// DRIVE cycle, so back-to-back pulses have no zero gap between them.

// One pending bit: set has priority over clear in the same cycle.
module prio_pend_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic set,
   input  logic clr,
   output logic q
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= 1'b0;
      else        q <= (q & ~clr) | set;
endmodule

module prio_decoder_seq #(
   parameter int N    = 4,
   parameter int HOLD = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      in_code,
   input  logic              in_z,
   output logic [(1<<N)-1:0] out_onehot,
   output logic              out_active,
   output logic [(1<<N)-1:0] pending,
   input  logic [(1<<N)-1:0] clr,
   output logic [7:0]        null_cnt
);
   localparam int W = 1 << N;
   localparam logic [7:0] CNT_INIT = 8'(HOLD - 1);

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t         state;
   logic [7:0]     cnt;
   logic           xfer;
   logic [W-1:0]   dec;
   logic [W-1:0]   set_vec;

`ifdef PRIO_DEC_B2B_EN
   assign in_ready = (state == IDLE) || (cnt == 8'd0);
`else
   assign in_ready = (state == IDLE);
`endif

   assign xfer    = in_valid && in_ready;
   assign dec     = {{(W-1){1'b0}}, 1'b1} << in_code;
   assign set_vec = (xfer && in_z) ? dec : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         out_onehot <= '0;
         out_active <= 1'b0;
         null_cnt   <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  if (in_z) begin
                     out_onehot <= dec;
                     out_active <= 1'b1;
                     cnt        <= CNT_INIT;
                     state      <= DRIVE;
                  end else if (null_cnt != 8'hFF) begin
                     null_cnt <= null_cnt + 8'd1;
                  end
               end
            end
            DRIVE: begin
               if (cnt != 8'd0) begin
                  cnt <= cnt - 8'd1;
               end else begin
`ifdef PRIO_DEC_B2B_EN
                  // The last pulse cycle doubles as an accept slot.
                  if (xfer && in_z) begin
                     out_onehot <= dec;
                     out_active <= 1'b1;
                     cnt        <= CNT_INIT;
                  end else begin
                     out_onehot <= '0;
                     out_active <= 1'b0;
                     state      <= IDLE;
                     if (xfer && null_cnt != 8'hFF) null_cnt <= null_cnt + 8'd1;
                  end
`else
                  out_onehot <= '0;
                  out_active <= 1'b0;
                  state      <= IDLE;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // One sticky cell per output lane.
   for (genvar i = 0; i < W; i++) begin : g_pend
      prio_pend_bit u_pend (
         .clk  (clk),
         .rst_n(rst_n),
         .set  (set_vec[i]),
         .clr  (clr[i]),
         .q    (pending[i])
      );
   end
endmodule
